// File: rtl/npu_dram_arbiter.sv
// npu_dram_arbiter: round-robin arbiter with burst lock sharing one single-beat DRAM port.
// Define NPU_ARB_TIMEOUT_EN to add a BUSY watchdog that force-completes stalled beats.
module npu_dram_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0]             lock,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
   input  logic [NUM_REQ-1:0]             req_we,
   output logic [NUM_REQ-1:0]             grant,
   output logic [NUM_REQ-1:0]             ack,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [ADDR_WIDTH-1:0]          dram_addr,
   output logic [DATA_WIDTH-1:0]          dram_wdata,
   input  logic [DATA_WIDTH-1:0]          dram_rdata,
   output logic                           dram_we,
   output logic                           dram_ce,
   input  logic                           dram_ready,
   output logic                           busy,
   output logic                           timeout_err
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
   state_t                 state, state_nxt;
   logic [NUM_REQ-1:0]     grant_nxt, ack_nxt;
   logic [DATA_WIDTH-1:0]  rdata_nxt, wdata_nxt, sel_wdata;
   logic [ADDR_WIDTH-1:0]  addr_nxt, sel_addr;
   logic                   we_nxt, ce_nxt, sel_we;
   logic [IW-1:0]          rr_last, rr_last_nxt, lock_idx, lock_idx_nxt, win;
   logic                   lock_vld, lock_vld_nxt;
   logic                   tmo_ack;
`ifdef NPU_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]          cnt, cnt_nxt;
   logic                   tmo_ack_nxt, terr_nxt;
`else
   assign tmo_ack     = 1'b0;
   assign timeout_err = 1'b0;
`endif
   assign busy = (state != IDLE);
   // Scan from farthest to nearest so the nearest requester after rr_last wins last.
   always_comb begin
      win = '0;
      for (int k = NUM_REQ; k >= 1; k--)
         if (req[IW'((int'(rr_last) + k) % NUM_REQ)]) win = IW'((int'(rr_last) + k) % NUM_REQ);
      if (lock_vld && req[lock_idx]) win = lock_idx;
   end
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         if (win == IW'(i)) begin
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_we    = req_we[i];
         end
   end
   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      ack_nxt      = '0;
      rdata_nxt    = rdata;
      addr_nxt     = dram_addr;
      wdata_nxt    = dram_wdata;
      we_nxt       = dram_we;
      ce_nxt       = dram_ce;
      rr_last_nxt  = rr_last;
      lock_vld_nxt = lock_vld;
      lock_idx_nxt = lock_idx;
`ifdef NPU_ARB_TIMEOUT_EN
      cnt_nxt      = cnt;
      tmo_ack_nxt  = tmo_ack;
      terr_nxt     = timeout_err;
`endif
      case (state)
         IDLE: if (|req) begin
            state_nxt   = BUSY;
            grant_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
            addr_nxt    = sel_addr;
            wdata_nxt   = sel_wdata;
            we_nxt      = sel_we;
            ce_nxt      = 1'b1;
            rr_last_nxt = win;
`ifdef NPU_ARB_TIMEOUT_EN
            cnt_nxt     = '0;
            tmo_ack_nxt = 1'b0;
`endif
         end
         BUSY: if (dram_ready) begin
            state_nxt = ACK;
            rdata_nxt = dram_rdata;
            ce_nxt    = 1'b0;
            ack_nxt   = grant;
         end
`ifdef NPU_ARB_TIMEOUT_EN
         else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state_nxt    = ACK;
            rdata_nxt    = '0;
            ce_nxt       = 1'b0;
            ack_nxt      = grant;
            terr_nxt     = 1'b1;
            lock_vld_nxt = 1'b0;
            tmo_ack_nxt  = 1'b1;
         end else cnt_nxt = cnt + 1'b1;
`endif
         ACK: begin
            state_nxt    = IDLE;
            grant_nxt    = '0;
            lock_vld_nxt = lock[rr_last] & ~tmo_ack;
            lock_idx_nxt = rr_last;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= '0;
         ack        <= '0;
         rdata      <= '0;
         dram_addr  <= '0;
         dram_wdata <= '0;
         dram_we    <= 1'b0;
         dram_ce    <= 1'b0;
         rr_last    <= IW'(NUM_REQ - 1);
         lock_vld   <= 1'b0;
         lock_idx   <= '0;
`ifdef NPU_ARB_TIMEOUT_EN
         cnt         <= '0;
         tmo_ack     <= 1'b0;
         timeout_err <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         ack        <= ack_nxt;
         rdata      <= rdata_nxt;
         dram_addr  <= addr_nxt;
         dram_wdata <= wdata_nxt;
         dram_we    <= we_nxt;
         dram_ce    <= ce_nxt;
         rr_last    <= rr_last_nxt;
         lock_vld   <= lock_vld_nxt;
         lock_idx   <= lock_idx_nxt;
`ifdef NPU_ARB_TIMEOUT_EN
         cnt         <= cnt_nxt;
         tmo_ack     <= tmo_ack_nxt;
         timeout_err <= terr_nxt;
`endif
      end
   end
endmodule

// File: tb/tb_npu_dram_arbiter.sv
// tb_npu_dram_arbiter: directed checks of arbitration, locking, write hold, reset and timeout.
module tb_npu_dram_arbiter;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [2:0]  req = '0, lock = '0, req_we = '0;
   logic [31:0] a [3];
   logic [15:0] wd [3];
   logic [2:0]  grant, ack;
   logic [15:0] rdata, dram_wdata, dram_rdata = '0;
   logic [31:0] dram_addr;
   logic        dram_we, dram_ce, dram_ready, busy, timeout_err;
   logic        auto_rdy = 1'b0, man_rdy = 1'b0;
   int          n_chk = 0, n_fail = 0;
   assign dram_ready = auto_rdy ? dram_ce : man_rdy;
   npu_dram_arbiter #(.NUM_REQ(3), .DATA_WIDTH(16), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
      .req_addr({a[2], a[1], a[0]}), .req_wdata({wd[2], wd[1], wd[0]}), .req_we(req_we),
      .grant(grant), .ack(ack), .rdata(rdata), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
      .dram_rdata(dram_rdata), .dram_we(dram_we), .dram_ce(dram_ce), .dram_ready(dram_ready),
      .busy(busy), .timeout_err(timeout_err));
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      #2;
      n_chk++; if ({grant, ack, dram_ce, dram_we, busy, timeout_err} !== 10'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", {grant, ack, dram_ce, dram_we, busy, timeout_err}); end
      n_chk++; if ({rdata, dram_addr, dram_wdata} !== 64'b0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {rdata, dram_addr, dram_wdata}); end
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      n_chk++; if (grant !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: grant %b busy %b want 000 0", grant, busy); end
   endtask
   task automatic test_single_read;
      a[0] = 32'h100; req_we = 3'b000; dram_rdata = 16'h1234; man_rdy = 1'b0; req = 3'b001;
      tick;
      n_chk++; if (dram_ce !== 1'b1 || dram_addr !== 32'h100 || grant !== 3'b001 || dram_we !== 1'b0) begin n_fail++; $display("FAIL read_issue: ce %b addr %h grant %b we %b want 1 100 001 0", dram_ce, dram_addr, grant, dram_we); end
      tick;
      n_chk++; if (dram_ce !== 1'b1 || ack !== 3'b000) begin n_fail++; $display("FAIL read_wait: ce %b ack %b want 1 000", dram_ce, ack); end
      man_rdy = 1'b1;
      tick;
      n_chk++; if (ack !== 3'b001 || rdata !== 16'h1234 || dram_ce !== 1'b0 || grant !== 3'b001) begin n_fail++; $display("FAIL read_ack: ack %b rdata %h ce %b grant %b want 001 1234 0 001", ack, rdata, dram_ce, grant); end
      req = 3'b000; man_rdy = 1'b0; dram_rdata = 16'hDEAD;
      tick;
      n_chk++; if (ack !== 3'b000 || grant !== 3'b000 || busy !== 1'b0 || rdata !== 16'h1234) begin n_fail++; $display("FAIL read_done: ack %b grant %b busy %b rdata %h want 000 000 0 1234", ack, grant, busy, rdata); end
   endtask
   task automatic test_round_robin;
      logic [2:0] e;
      rst_n = 1'b0; tick; rst_n = 1'b1;
      auto_rdy = 1'b1; req = 3'b111;
      for (int b = 0; b < 6; b++) begin
         e = 3'b001 << (b % 3);
         tick;
         n_chk++; if (grant !== e || dram_ce !== 1'b1) begin n_fail++; $display("FAIL rr_grant_%0d: grant %b ce %b want %b 1", b, grant, dram_ce, e); end
         tick;
         n_chk++; if (ack !== e) begin n_fail++; $display("FAIL rr_ack_%0d: got %b want %b", b, ack, e); end
         req = req & ~e;
         tick;
         n_chk++; if (grant !== 3'b000) begin n_fail++; $display("FAIL rr_idle_%0d: got %b want 000", b, grant); end
         req = 3'b111;
      end
      req = 3'b000; auto_rdy = 1'b0;
      tick;
      tick;
      tick;
   endtask
   task automatic test_lock;
      rst_n = 1'b0; tick; rst_n = 1'b1;
      auto_rdy = 1'b1; req = 3'b011; lock = 3'b001;
      for (int b = 0; b < 4; b++) begin
         tick;
         n_chk++; if (grant !== 3'b001) begin n_fail++; $display("FAIL lock_grant_%0d: got %b want 001", b, grant); end
         tick;
         n_chk++; if (ack !== 3'b001) begin n_fail++; $display("FAIL lock_ack_%0d: got %b want 001", b, ack); end
         if (b == 3) lock = 3'b000;
         tick;
      end
      tick;
      n_chk++; if (grant !== 3'b010) begin n_fail++; $display("FAIL lock_release: got %b want 010", grant); end
      tick;
      req = 3'b000; auto_rdy = 1'b0;
      tick;
   endtask
   task automatic test_write;
      a[1] = 32'h2000; wd[1] = 16'h5678; req_we = 3'b010; man_rdy = 1'b0; req = 3'b010;
      tick;
      n_chk++; if (grant !== 3'b010 || dram_we !== 1'b1 || dram_wdata !== 16'h5678 || dram_addr !== 32'h2000) begin n_fail++; $display("FAIL wr_issue: grant %b we %b wdata %h addr %h want 010 1 5678 2000", grant, dram_we, dram_wdata, dram_addr); end
      wd[1] = 16'hFFFF; a[1] = 32'h0; req_we = 3'b000;
      tick;
      tick;
      n_chk++; if (dram_we !== 1'b1 || dram_wdata !== 16'h5678 || dram_addr !== 32'h2000 || dram_ce !== 1'b1) begin n_fail++; $display("FAIL wr_hold: we %b wdata %h addr %h ce %b want 1 5678 2000 1", dram_we, dram_wdata, dram_addr, dram_ce); end
      dram_rdata = 16'hABCD; man_rdy = 1'b1;
      tick;
      n_chk++; if (ack !== 3'b010 || rdata !== 16'hABCD) begin n_fail++; $display("FAIL wr_ack: ack %b rdata %h want 010 abcd", ack, rdata); end
      req = 3'b000; man_rdy = 1'b0;
      tick;
   endtask
   task automatic test_reset_mid_busy;
      a[0] = 32'h300; a[2] = 32'h700; req = 3'b101;
      tick;
      n_chk++; if (grant !== 3'b100 || dram_addr !== 32'h700) begin n_fail++; $display("FAIL mid_grant: grant %b addr %h want 100 700", grant, dram_addr); end
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++; if (dram_ce !== 1'b0 || grant !== 3'b000 || ack !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset: ce %b grant %b ack %b busy %b want 0 000 000 0", dram_ce, grant, ack, busy); end
      man_rdy = 1'b1;
      tick;
      tick;
      n_chk++; if (ack !== 3'b000) begin n_fail++; $display("FAIL mid_no_ack: got %b want 000", ack); end
      rst_n = 1'b1; man_rdy = 1'b0;
      tick;
      n_chk++; if (grant !== 3'b001 || dram_addr !== 32'h300) begin n_fail++; $display("FAIL mid_regrant: grant %b addr %h want 001 300", grant, dram_addr); end
      man_rdy = 1'b1;
      tick;
      n_chk++; if (ack !== 3'b001) begin n_fail++; $display("FAIL mid_ack: got %b want 001", ack); end
      req = 3'b000; man_rdy = 1'b0;
      tick;
   endtask
   task automatic test_timeout;
      dram_rdata = 16'h5555; man_rdy = 1'b0; req = 3'b001;
      tick;
      n_chk++; if (grant !== 3'b001 || dram_ce !== 1'b1) begin n_fail++; $display("FAIL to_grant: grant %b ce %b want 001 1", grant, dram_ce); end
`ifdef NPU_ARB_TIMEOUT_EN
      for (int c = 0; c < 7; c++) begin
         tick;
         n_chk++; if (ack !== 3'b000 || dram_ce !== 1'b1) begin n_fail++; $display("FAIL to_wait_%0d: ack %b ce %b want 000 1", c, ack, dram_ce); end
      end
      tick;
      n_chk++; if (ack !== 3'b001 || rdata !== 16'h0 || timeout_err !== 1'b1 || dram_ce !== 1'b0) begin n_fail++; $display("FAIL to_fire: ack %b rdata %h err %b ce %b want 001 0 1 0", ack, rdata, timeout_err, dram_ce); end
      req = 3'b000;
      tick;
      tick;
      n_chk++; if (timeout_err !== 1'b1 || ack !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL to_sticky: err %b ack %b busy %b want 1 000 0", timeout_err, ack, busy); end
`else
      repeat (20) tick;
      n_chk++; if (dram_ce !== 1'b1 || ack !== 3'b000 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL no_to_wait: ce %b ack %b err %b want 1 000 0", dram_ce, ack, timeout_err); end
      man_rdy = 1'b1;
      tick;
      n_chk++; if (ack !== 3'b001 || rdata !== 16'h5555 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL no_to_ack: ack %b rdata %h err %b want 001 5555 0", ack, rdata, timeout_err); end
      req = 3'b000; man_rdy = 1'b0;
      tick;
`endif
   endtask
   initial begin
      for (int i = 0; i < 3; i++) begin
         a[i] = '0;
         wd[i] = '0;
      end
      test_reset;
      test_single_read;
      test_round_robin;
      test_lock;
      test_write;
      test_reset_mid_busy;
      test_timeout;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1);
   end
endmodule
